// File: rtl/mux2_arb_pkg.sv
// Shared types and constants for the two-requester round-robin mux arbiter.
//   arb_state_t : arbiter FSM state. The grant encodings equal the one-hot
//                 grant vector {B, A}, so the state drives `grant` directly.
//   SEL_A/SEL_B : mux select values for requester A and requester B.
package mux2_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    GNT_A = 2'b01,
    GNT_B = 2'b10
  } arb_state_t;

  localparam logic SEL_A = 1'b0;
  localparam logic SEL_B = 1'b1;

endpackage

// File: rtl/mux2_arb_beat_cnt.sv
// Beat counter for the current grant.
// Ports:
//   clk, rst : clock and asynchronous active-high reset
//   clr      : return the count to zero (takes priority over inc)
//   inc      : count one accepted beat
//   term     : high when the count has reached MAX_BURST-1, so the next
//              accepted beat is the last one this grant may carry
module mux2_arb_beat_cnt #(
  parameter int MAX_BURST = 4,
  parameter int CNT_W     = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic inc,
  output logic term
);

  logic [CNT_W-1:0] cnt_r;

  // Beat count register: cleared on release, stepped on each non-releasing beat.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_r <= {CNT_W{1'b0}};
    end else if (clr) begin
      cnt_r <= {CNT_W{1'b0}};
    end else if (inc) begin
      cnt_r <= cnt_r + CNT_W'(1'b1);
    end else begin
      cnt_r <= cnt_r;
    end
  end

  assign term = (cnt_r == CNT_W'(MAX_BURST - 1));

endmodule

// File: rtl/mux2_arbiter.sv
// Round-robin arbiter that shares one 2:1 mux output channel between
// requesters A and B, holding the grant for a packet up to MAX_BURST beats.
// Ports:
//   clk, rst                       : clock, asynchronous active-high reset
//   a_valid/a_data/a_last, a_ready : requester A beat and its accept
//   b_valid/b_data/b_last, b_ready : requester B beat and its accept
//   out_valid/out_data/out_last    : muxed beat toward the downstream sink
//   out_ready                      : downstream accepts the beat
//   sel                            : registered mux select (0 = A, 1 = B)
//   grant                          : one-hot grant {B, A}, 00 when idle
//   preempt                        : one-cycle pulse after a forced release
module mux2_arbiter
  import mux2_arb_pkg::*;
#(
  parameter int DATA_W    = 1,
  parameter int MAX_BURST = 4,
  parameter int CNT_W     = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              a_valid,
  input  logic [DATA_W-1:0] a_data,
  input  logic              a_last,
  output logic              a_ready,
  input  logic              b_valid,
  input  logic [DATA_W-1:0] b_data,
  input  logic              b_last,
  output logic              b_ready,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  output logic              out_last,
  input  logic              out_ready,
  output logic              sel,
  output logic [1:0]        grant,
  output logic              preempt
);

  arb_state_t state_r, next_state_s;
  logic       sel_r, sel_next_s;
  logic       last_b_r, last_b_next_s;  // last served requester was B
  logic       preempt_r, preempt_next_s;
  logic       cnt_clr_s, cnt_inc_s, term_s, beat_s;

  mux2_arb_beat_cnt #(
    .MAX_BURST(MAX_BURST),
    .CNT_W    (CNT_W)
  ) u_beat_cnt (
    .clk (clk),
    .rst (rst),
    .clr (cnt_clr_s),
    .inc (cnt_inc_s),
    .term(term_s)
  );

  // Datapath and handshakes: only the granted requester sees out_ready.
  always_comb begin
    out_data  = (sel_r == SEL_B) ? b_data : a_data;
    out_last  = (sel_r == SEL_B) ? b_last : a_last;
    out_valid = 1'b0;
    a_ready   = 1'b0;
    b_ready   = 1'b0;
    case (state_r)
      GNT_A: begin
        out_valid = a_valid;
        a_ready   = out_ready;
      end
      GNT_B: begin
        out_valid = b_valid;
        b_ready   = out_ready;
      end
      default: begin
        out_valid = 1'b0;
      end
    endcase
  end

  assign beat_s = out_valid & out_ready;

  // Next-state logic: arbitration in IDLE, release on last beat or burst limit.
  always_comb begin
    next_state_s   = state_r;
    last_b_next_s  = last_b_r;
    preempt_next_s = 1'b0;
    cnt_clr_s      = 1'b0;
    cnt_inc_s      = 1'b0;
    case (state_r)
      IDLE: begin
        // Tie goes to whoever was not served last.
        if (a_valid && (!b_valid || last_b_r)) begin
          next_state_s = GNT_A;
        end else if (b_valid) begin
          next_state_s = GNT_B;
        end else begin
          next_state_s = IDLE;
        end
      end
      GNT_A: begin
        if (beat_s && (a_last || term_s)) begin
          next_state_s   = b_valid ? GNT_B : IDLE;
          last_b_next_s  = 1'b0;
          preempt_next_s = ~a_last;  // a coincident last counts as normal
          cnt_clr_s      = 1'b1;
        end else if (beat_s) begin
          cnt_inc_s = 1'b1;
        end else begin
          next_state_s = GNT_A;
        end
      end
      GNT_B: begin
        if (beat_s && (b_last || term_s)) begin
          next_state_s   = a_valid ? GNT_A : IDLE;
          last_b_next_s  = 1'b1;
          preempt_next_s = ~b_last;
          cnt_clr_s      = 1'b1;
        end else if (beat_s) begin
          cnt_inc_s = 1'b1;
        end else begin
          next_state_s = GNT_B;
        end
      end
      default: begin
        next_state_s = IDLE;
      end
    endcase
  end

  // Select follows the upcoming grant and holds its value through IDLE.
  always_comb begin
    case (next_state_s)
      GNT_A:   sel_next_s = SEL_A;
      GNT_B:   sel_next_s = SEL_B;
      default: sel_next_s = sel_r;
    endcase
  end

  // Arbiter state registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r   <= IDLE;
      sel_r     <= SEL_A;
      last_b_r  <= 1'b1;
      preempt_r <= 1'b0;
    end else begin
      state_r   <= next_state_s;
      sel_r     <= sel_next_s;
      last_b_r  <= last_b_next_s;
      preempt_r <= preempt_next_s;
    end
  end

  assign sel     = sel_r;
  assign grant   = state_r;
  assign preempt = preempt_r;

endmodule

// File: doc/mux2_arbiter.md
Name: mux2_arbiter

Overview:
- Round-robin arbiter and sequencer that shares one 2:1 mux output channel between two requesters, A and B.
- Drives the mux select and valid/ready handshakes, and holds the grant for a multi-beat packet up to a burst limit.
- Sits directly in front of the Logic_mux2 datapath. Its `sel` output drives the mux select input.

Parameters:
- DATA_W, 1, width of each requester's data and of the muxed output
- MAX_BURST, 4, max beats per grant before forced release (legal range 1..15)
- CNT_W, 4, width of the beat counter; must satisfy 2^CNT_W > MAX_BURST

Ports:
- clk  input  1  single system clock, rising edge
- rst  input  1  asynchronous, active-high reset
- a_valid  input  1  requester A has a beat
- a_data  input  DATA_W  requester A beat data
- a_last  input  1  final beat of A's packet
- a_ready  output  1  A beat accepted this cycle
- b_valid  input  1  requester B has a beat
- b_data  input  DATA_W  requester B beat data
- b_last  input  1  final beat of B's packet
- b_ready  output  1  B beat accepted this cycle
- out_valid  output  1  muxed beat valid
- out_data  output  DATA_W  muxed data: sel ? b_data : a_data
- out_last  output  1  muxed last flag
- out_ready  input  1  downstream accepts beat
- sel  output  1  mux select (0 = A, 1 = B), registered
- grant  output  2  one-hot current grant {B, A}; 00 when idle
- preempt  output  1  one-cycle pulse on forced release by MAX_BURST

Behaviour:
- Clock and reset: single clock; reset is asynchronous and active-high. Asserting rst immediately forces:
  - state = IDLE, sel = 0, grant = 00, beat_cnt = 0, preempt = 0, last_served = B.
  - Consequently out_valid, a_ready and b_ready are 0 while rst is high.
- States:
  - IDLE
  - GNT_A (sel = 0, grant = 01)
  - GNT_B (sel = 1, grant = 10)
- IDLE transitions:
  - a_valid only -> GNT_A.
  - b_valid only -> GNT_B.
  - Both valid -> the requester that is not last_served.
  - Neither valid -> stay in IDLE.
  - Grant latency is 1 cycle: a request seen in IDLE is granted next cycle. No beat transfers in IDLE.
- sel in IDLE holds its previous value.
- Datapath is combinational:
  - out_data and out_last are the selected requester's data and last.
  - out_valid = granted requester's valid; 0 in IDLE.
  - Granted requester's ready = out_ready. Non-granted requester's ready = 0.
- Beat: transfer occurs when out_valid && out_ready. On each beat beat_cnt increments.
- Release from GNT_x happens on the beat where either condition holds:
  - x_last = 1 (normal release), or
  - beat_cnt + 1 == MAX_BURST (forced release; preempt = 1 the next cycle).
  - If both hold on the same beat, the release counts as normal and preempt stays 0.
- On release:
  - last_served = x and beat_cnt = 0.
  - Next state is GNT_other if other_valid is 1 that cycle, else IDLE.
  - The other requester is granted back-to-back with no idle cycle.
- Forced release mid-packet: the remainder of the packet resumes on x's next grant. The arbiter does not reorder or drop data.
- Granted requester dropping valid: the grant is held indefinitely; there is no timeout, and beat_cnt is unchanged.
- out_ready low: no beat and no count; state holds.
- MAX_BURST = 1: every beat releases, giving strict alternation whenever both requesters are valid.
- Reset mid-packet: the packet is abandoned. After reset deasserts, arbitration restarts from IDLE with A winning a tie.

Decomposition:
- Shared package mux2_arb_pkg:
  - state enum arb_state_t {IDLE, GNT_A, GNT_B}
  - localparams SEL_A = 1'b0 and SEL_B = 1'b1
- One sub-module is natural: mux2_arb_beat_cnt.
  - Holds the beat counter with clear/increment.
  - Outputs a terminal flag at MAX_BURST-1.
- The data mux stays inline, or instantiates Logic_mux2 with sel driving its select.

Test Plan:
- Reset: rst = 1 mid-transfer with a_valid = 1 -> same-cycle grant = 00, sel = 0, out_valid = 0, a_ready = 0. After release, a_valid = 1 -> grant = 01 one cycle later.
- Single requester: A sends a 3-beat packet (data 1,0,1, last on beat 3), out_ready = 1 -> out_data = 1,0,1. State returns to IDLE the cycle after beat 3; b_ready = 0 throughout.
- Tie after reset: a_valid = b_valid = 1 in IDLE -> GNT_A first. On A's last beat, grant switches to 10 the next cycle with no IDLE cycle.
- Forced release, MAX_BURST = 4: A sends a 6-beat packet while B is valid -> 4 A beats then preempt = 1 and grant = 10. B's 1-beat packet completes, then A is regranted for its remaining 2 beats.
- Backpressure: out_ready = 0 for 3 cycles during GNT_B -> b_ready = 0, beat_cnt holds, no transfer. Resuming out_ready = 1 continues the same packet.
- Coincident last and limit: MAX_BURST = 2, A sends a 2-beat packet with last on beat 2 -> normal release, preempt stays 0.
